imem_loader: RTL

//  Writer side of the instruction-memory interface that the CPU core only reads.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_byte_packer.sv | 32 +++
 rtl/imem_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and
// the small helpers the top-level uses.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [31:0] WORD_STRIDE = 32'd4;

  // START is only honoured where no frame is in flight.
  function automatic logic start_ok(input state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// 8->32 big-endian shift register with a 2-bit byte counter; FULL flags that
// three bytes are already held, so the next SHIFT completes the word.
module byte_packer (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        CLR,
  input  logic        SHIFT,
  input  logic [7:0]  BYTE,
  output logic [31:0] WORD,
  output logic        FULL
);

  logic [1:0]  r_cnt;
  logic [31:0] r_word;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
    end else if (CLR) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
    end else if (SHIFT) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= {r_word[23:0], BYTE};
    end
  end

  assign WORD = r_word;
  assign FULL = (r_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Host-link loader: unpacks a framed byte stream into 32-bit words, writes
// them to instruction memory, verifies an XOR checksum and releases the core.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 64
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        BYTE_VALID,
  input  logic [7:0]  BYTE_DATA,
  output logic        BYTE_READY,
  output logic        MEM_WE,
  output logic [31:0] MEM_A,
  output logic [31:0] MEM_WD,
  output logic        CPU_HOLD,
  output logic        DONE,
  output logic        ERROR
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t      r_state;
  logic        r_ready;
  logic        r_we;
  logic [31:0] r_addr;
  logic        r_hold;
  logic        r_done;
  logic        r_err;
  logic [15:0] r_len;
  logic [15:0] r_wcnt;
  logic [7:0]  r_csum;

  logic        w_xfer;
  logic        w_start;
  logic        w_shift;
  logic        w_clr;
  logic        w_full;
  logic [15:0] w_len_n;
  logic [31:0] w_word;

  assign w_xfer  = BYTE_VALID & r_ready;
  assign w_start = START & start_ok(r_state);
  assign w_shift = w_xfer & (r_state == ST_DATA);
  assign w_clr   = (r_state == ST_IDLE) | w_start;
  assign w_len_n = {r_len[15:8], BYTE_DATA};

  byte_packer u_packer (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .CLR     (w_clr),
    .SHIFT   (w_shift),
    .BYTE    (BYTE_DATA),
    .WORD    (w_word),
    .FULL    (w_full)
  );

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= BASE_ADDR;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_len   <= 16'd0;
      r_wcnt  <= 16'd0;
      r_csum  <= 8'd0;
    end else begin
      case (r_state)
        // A restart from DONE/ERR takes the same path as a fresh start.
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (w_start) begin
            r_state <= ST_LEN_HI;
            r_ready <= 1'b1;
            r_addr  <= BASE_ADDR;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_wcnt  <= 16'd0;
            r_csum  <= 8'd0;
          end
        end
        ST_LEN_HI: begin
          if (w_xfer) begin
            r_len[15:8] <= BYTE_DATA;
            r_state     <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (w_xfer) begin
            r_len[7:0] <= BYTE_DATA;
            if (32'(w_len_n) > MAX_W) begin
              r_state <= ST_ERR;
              r_ready <= 1'b0;
              r_err   <= 1'b1;
            end else if (w_len_n == 16'd0) begin
              r_state <= ST_CHECK;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
            r_csum <= r_csum ^ BYTE_DATA;
            if (w_full) begin
              r_state <= ST_WRITE;
              r_ready <= 1'b0;
              r_we    <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          r_we    <= 1'b0;
          r_ready <= 1'b1;
          r_addr  <= r_addr + WORD_STRIDE;
          r_wcnt  <= r_wcnt + 16'd1;
          r_state <= (r_wcnt + 16'd1 == r_len) ? ST_CHECK : ST_DATA;
        end
        ST_CHECK: begin
          if (w_xfer) begin
            r_ready <= 1'b0;
            if (BYTE_DATA == r_csum) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign BYTE_READY = r_ready;
  assign MEM_WE     = r_we;
  assign MEM_A      = r_addr;
  assign MEM_WD     = w_word;
  assign CPU_HOLD   = r_hold;
  assign DONE       = r_done;
  assign ERROR      = r_err;

endmodule
